gf2_div_xk1_seq: RTL and testbench

//  Iterative exact divider over GF(2)[x]: computes Q = A / (1 + x^k), runtime k in 1..KMAX.

---
 rtl/gf2_toom_pkg.sv | 21 ++
 rtl/gf2_stride_pxor.sv | 47 ++++
 rtl/gf2_div_xk1_seq.sv | 134 +++++++++++++
 tb/tb_gf2_div_xk1_seq.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/gf2_toom_pkg.sv
// Shared types and constants for the GF(2)[x] Toom interpolation helpers.
// Holds the FSM state encoding, k_sel width and the divisor-exponent validity check.
package gf2_toom_pkg;

  localparam int KMAX_DEF = 4;
  localparam int K_SEL_W  = 3;
  localparam int N_DEF    = 4480;
  localparam int W_DEF    = 32;
  localparam int NWORDS   = N_DEF / W_DEF;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } state_t;

  function automatic logic is_valid_k(input logic [K_SEL_W-1:0] k, input int kmax);
    return (k != '0) && (int'(k) <= kmax);
  endfunction

endpackage

// File: rtl/gf2_stride_pxor.sv
// One W-bit word of the recurrence c_i = a_i ^ c_{i+k}: seed with the carried c bits,
// then a log-depth stride-k suffix XOR toward higher indices.
module gf2_stride_pxor
  import gf2_toom_pkg::*;
#(
  parameter int W    = W_DEF,
  parameter int KMAX = KMAX_DEF
) (
  input  logic [W-1:0]       word,
  input  logic [KMAX-1:0]    carry,
  input  logic [K_SEL_W-1:0] k,
  output logic [W-1:0]       c_word
);

  localparam int STEPS = $clog2(W);

  logic [W-1:0] cand [KMAX];

  // One constant-stride network per legal k; the runtime k only picks the result.
  for (genvar kk = 1; kk <= KMAX; kk++) begin : g_k
    localparam logic [KMAX-1:0] KMASK = ~({KMAX{1'b1}} << kk);

    logic [W-1:0] seed;
    logic [W-1:0] y;

    // carry[t] is c at position W+t of this word, so it lands on bit W-kk+t.
    assign seed = word ^ (W'(carry & KMASK) << (W - kk));

    always_comb begin
      y = seed;
      for (int s = 0; s < STEPS; s++) begin
        y = y ^ (y >> (kk << s));
      end
    end

    assign cand[kk-1] = y;
  end

  // NOTE: c_word is given a default before the selection loop so no input pattern leaves it unassigned (no latch).
  always_comb begin
    c_word = '0;
    for (int i = 0; i < KMAX; i++) begin
      if (int'(k) == i + 1) c_word = cand[i];
    end
  end

endmodule

// File: rtl/gf2_div_xk1_seq.sv
// Iterative exact divider Q = A / (1 + x^k) over GF(2)[x], MSB-first, W bits per cycle,
// with start/busy/done handshake, remainder and exact-division flag.
module gf2_div_xk1_seq
  import gf2_toom_pkg::*;
#(
  parameter int N    = NWORDS * W_DEF,
  parameter int W    = W_DEF,
  parameter int KMAX = KMAX_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [K_SEL_W-1:0] k_sel,
  input  logic [N-1:0]       in,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [N-1:0]       out,
  output logic [KMAX-1:0]    rem,
  output logic               exact
);

  localparam int WORDS = N / W;
  localparam int CNT_W = $clog2(WORDS + 1);

  if ((N % W) != 0 || W < KMAX) begin : g_bad_cfg
    $error("gf2_div_xk1_seq: N must be a multiple of W and W must be >= KMAX");
  end

  state_t             state;
  state_t             state_nxt;
  logic [N-1:0]       opnd;
  logic [N-1:0]       c_acc;
  logic [N-1:0]       c_acc_nxt;
  logic [KMAX-1:0]    carry;
  logic [KMAX-1:0]    kmask;
  logic [KMAX-1:0]    rem_nxt;
  logic [K_SEL_W-1:0] k_q;
  logic [CNT_W-1:0]   cnt;
  logic [W-1:0]       c_word;
  logic               accept;
  logic               reject;
  logic               last_word;

  gf2_stride_pxor #(
    .W    (W),
    .KMAX (KMAX)
  ) u_stage (
    .word   (opnd[N-1 -: W]),
    .carry  (carry),
    .k      (k_q),
    .c_word (c_word)
  );

  assign kmask     = ~({KMAX{1'b1}} << k_q);
  assign c_acc_nxt = (c_acc << W) | N'(c_word);
  assign rem_nxt   = c_acc_nxt[KMAX-1:0] & kmask;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    accept    = 1'b0;
    reject    = 1'b0;
    last_word = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (is_valid_k(k_sel, KMAX)) begin
            accept    = 1'b1;
            state_nxt = RUN;
          end else begin
            reject = 1'b1;
          end
        end
      end
      RUN: begin
        busy = 1'b1;
        if (cnt == CNT_W'(WORDS - 1)) begin
          last_word = 1'b1;
          state_nxt = FIN;
        end
      end
      FIN: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: the wide operand and accumulator are reset too, so an aborted run leaves nothing behind.
  always_ff @(posedge clk) begin
    if (rst) begin
      opnd  <= '0;
      c_acc <= '0;
      carry <= '0;
      k_q   <= '0;
      cnt   <= '0;
      err   <= 1'b0;
      out   <= '0;
      rem   <= '0;
      exact <= 1'b0;
    end else begin
      err <= reject;
      if (accept) begin
        opnd  <= in;
        k_q   <= k_sel;
        c_acc <= '0;
        carry <= '0;
        cnt   <= '0;
      end
      if (state == RUN) begin
        opnd  <= opnd << W;
        c_acc <= c_acc_nxt;
        carry <= c_word[KMAX-1:0] & kmask;
        cnt   <= cnt + 1'b1;
      end
      // Results are captured from the final word so they are already valid in the done cycle.
      if (last_word) begin
        out   <= c_acc_nxt >> k_q;
        rem   <= rem_nxt;
        exact <= (rem_nxt == '0);
      end
    end
  end

endmodule

// File: tb/tb_gf2_div_xk1_seq.sv
// Directed bench for gf2_div_xk1_seq: small N=16/W=4 instance with hand-computed vectors,
// plus a default-parameter instance checked on A = Q*(1+x^k).
module tb_gf2_div_xk1_seq;
  import gf2_toom_pkg::*;

  localparam int N    = 16;
  localparam int W    = 4;
  localparam int KMAX = 4;
  localparam int NW   = N / W;
  localparam int DN   = 4480;
  localparam int DW   = 32;
  localparam int DNW  = DN / DW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic               start;
  logic [K_SEL_W-1:0] k_sel;
  logic [N-1:0]       a_in;
  logic               busy, done, err, exact;
  logic [N-1:0]       q_out;
  logic [KMAX-1:0]    rem;

  logic               d_start;
  logic [K_SEL_W-1:0] d_k;
  logic [DN-1:0]      d_in;
  logic               d_busy, d_done, d_err, d_exact;
  logic [DN-1:0]      d_out;
  logic [KMAX_DEF-1:0] d_rem;

  gf2_div_xk1_seq #(.N(N), .W(W), .KMAX(KMAX)) u_dut (
    .clk(clk), .rst(rst), .start(start), .k_sel(k_sel), .in(a_in),
    .busy(busy), .done(done), .err(err), .out(q_out), .rem(rem), .exact(exact)
  );

  gf2_div_xk1_seq u_dut_def (
    .clk(clk), .rst(rst), .start(d_start), .k_sel(d_k), .in(d_in),
    .busy(d_busy), .done(d_done), .err(d_err), .out(d_out), .rem(d_rem), .exact(d_exact)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [2:0]  k;
    logic [15:0] a;
    logic [15:0] q;
    logic [3:0]  r;
    logic        ex;
  } vec_t;

  vec_t vecs [11];

  task automatic launch(input logic [2:0] k, input logic [15:0] a);
    @(negedge clk);
    start = 1'b1; k_sel = k; a_in = a;
    @(negedge clk);
    // Junk on k_sel/in while busy must not matter.
    start = 1'b0; k_sel = 3'd7; a_in = ~a;
  endtask

  task automatic wait_done(input int budget, output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!done && lat < budget);
  endtask

  task automatic run_vec(input int idx);
    int lat;
    vec_t v;
    v = vecs[idx];
    launch(v.k, v.a);
    check($sformatf("v%0d_busy", idx), 64'(busy), 64'd1);
    wait_done(20, lat);
    check($sformatf("v%0d_done", idx), 64'(done), 64'd1);
    check($sformatf("v%0d_lat", idx), 64'(1 + lat), 64'(NW + 1));
    check($sformatf("v%0d_busy_at_done", idx), 64'(busy), 64'd0);
    check($sformatf("v%0d_out", idx), 64'(q_out), 64'(v.q));
    check($sformatf("v%0d_rem", idx), 64'(rem), 64'(v.r));
    check($sformatf("v%0d_exact", idx), 64'(exact), 64'(v.ex));
    @(negedge clk);
    check($sformatf("v%0d_done_pulse", idx), 64'(done), 64'd0);
  endtask

  task automatic run_big(input int k, input int trial);
    logic [DN-1:0] q, a, m;
    int lat;
    for (int i = 0; i < DNW; i++) q[i*DW +: DW] = $urandom;
    m = '1;
    q = q & (m >> k);
    a = q ^ (q << k);
    @(negedge clk);
    d_start = 1'b1; d_k = K_SEL_W'(k); d_in = a;
    @(negedge clk);
    d_start = 1'b0; d_k = '0; d_in = '0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!d_done && lat < DNW + 20);
    check($sformatf("big%0d_done", trial), 64'(d_done), 64'd1);
    check($sformatf("big%0d_lat", trial), 64'(1 + lat), 64'(DNW + 1));
    check($sformatf("big%0d_rem", trial), 64'(d_rem), 64'd0);
    check($sformatf("big%0d_exact", trial), 64'(d_exact), 64'd1);
    for (int i = 0; i < DNW; i++)
      check($sformatf("big%0d_q_w%0d", trial, i), 64'(d_out[i*DW +: DW]), 64'(q[i*DW +: DW]));
    @(negedge clk);
  endtask

  initial begin
    int lat;
    int ndone;

    vecs[0]  = '{k: 3'd1, a: 16'h0003, q: 16'h0001, r: 4'h0, ex: 1'b1};
    vecs[1]  = '{k: 3'd1, a: 16'h0009, q: 16'h0007, r: 4'h0, ex: 1'b1};
    vecs[2]  = '{k: 3'd3, a: 16'h0009, q: 16'h0001, r: 4'h0, ex: 1'b1};
    vecs[3]  = '{k: 3'd2, a: 16'h0001, q: 16'h0000, r: 4'h1, ex: 1'b0};
    vecs[4]  = '{k: 3'd1, a: 16'hFFFF, q: 16'h5555, r: 4'h0, ex: 1'b1};
    vecs[5]  = '{k: 3'd4, a: 16'h1111, q: 16'h0101, r: 4'h0, ex: 1'b1};
    vecs[6]  = '{k: 3'd2, a: 16'h8000, q: 16'h2AAA, r: 4'h2, ex: 1'b0};
    vecs[7]  = '{k: 3'd4, a: 16'h000B, q: 16'h0000, r: 4'hB, ex: 1'b0};
    vecs[8]  = '{k: 3'd3, a: 16'h0000, q: 16'h0000, r: 4'h0, ex: 1'b1};
    vecs[9]  = '{k: 3'd3, a: 16'h8000, q: 16'h1249, r: 4'h1, ex: 1'b0};
    vecs[10] = '{k: 3'd4, a: 16'hFFFF, q: 16'h0F0F, r: 4'h0, ex: 1'b1};

    rst = 1'b1; start = 1'b0; k_sel = '0; a_in = '0;
    d_start = 1'b0; d_k = '0; d_in = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_out", 64'(q_out), 64'd0);
    check("rst_rem", 64'(rem), 64'd0);
    check("rst_exact", 64'(exact), 64'd0);
    check("rst_def_out_zero", 64'(d_out == '0), 64'd1);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) run_vec(i);

    // Rejected k values: err pulses, nothing starts, results untouched.
    @(negedge clk);
    start = 1'b1; k_sel = 3'd0; a_in = 16'h1234;
    @(negedge clk);
    check("err_k0", 64'(err), 64'd1);
    check("err_k0_busy", 64'(busy), 64'd0);
    k_sel = 3'd5;
    @(negedge clk);
    check("err_k5", 64'(err), 64'd1);
    check("err_k5_busy", 64'(busy), 64'd0);
    start = 1'b0;
    @(negedge clk);
    check("err_pulse_end", 64'(err), 64'd0);
    check("err_out_kept", 64'(q_out), 64'h0F0F);
    check("err_exact_kept", 64'(exact), 64'd1);

    // start while busy is dropped silently.
    launch(3'd1, 16'h0009);
    @(negedge clk);
    start = 1'b1; k_sel = 3'd2; a_in = 16'h0001;
    @(negedge clk);
    start = 1'b0;
    check("busy_start_no_err", 64'(err), 64'd0);
    wait_done(20, lat);
    check("busy_start_done", 64'(done), 64'd1);
    check("busy_start_out", 64'(q_out), 64'h0007);
    check("busy_start_rem", 64'(rem), 64'd0);
    check("busy_start_exact", 64'(exact), 64'd1);
    ndone = 0;
    repeat (NW + 3) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("busy_start_no_queue", 64'(ndone), 64'd0);

    // start held across the done cycle is first accepted in the following cycle.
    launch(3'd2, 16'h0001);
    wait_done(20, lat);
    check("b2b_first_done", 64'(done), 64'd1);
    start = 1'b1; k_sel = 3'd1; a_in = 16'h0003;
    @(negedge clk);
    check("b2b_idle_not_busy", 64'(busy), 64'd0);
    @(negedge clk);
    start = 1'b0;
    check("b2b_busy", 64'(busy), 64'd1);
    wait_done(20, lat);
    check("b2b_gap", 64'(2 + lat), 64'(NW + 2));
    check("b2b_out", 64'(q_out), 64'h0001);
    check("b2b_exact", 64'(exact), 64'd1);

    // Reset two cycles into a run aborts it with no done.
    launch(3'd1, 16'hFFFF);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_out", 64'(q_out), 64'd0);
    check("midrst_exact", 64'(exact), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    rst = 1'b0;
    ndone = 0;
    repeat (NW + 3) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("midrst_no_done", 64'(ndone), 64'd0);
    run_vec(6);

    run_big(1, 0);
    run_big(KMAX_DEF, 1);
    run_big($urandom_range(1, KMAX_DEF), 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
